// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: multi-cycle signed/unsigned MULT and
// a 1-bit-per-cycle restoring divider, with busy for pipeline interlock.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Terminal counter values: MUL counts busy cycles, DIV counts the 32 iterations
    // and then spends one extra cycle on the sign fix.
    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state_reg;
    logic        busy_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [4:0]  count_reg;
    logic        fix_reg;
    logic        sgn_reg;
    logic [31:0] opa_reg;
    logic [31:0] opb_reg;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;

    logic        done;
    logic        accept;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] mag_a_in;
    logic        q_neg;
    logic        r_neg;

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // A new request is taken in IDLE or on the completion edge itself, so a start
    // presented during the final busy cycle chains with no gap in busy.
    assign done   = ((state_reg == MUL) && (count_reg == MUL_LAST)) ||
                    ((state_reg == DIV) && fix_reg);
    assign accept = start && ((state_reg == IDLE) || done);

    always_comb begin
        a_ext    = sgn_reg ? {{32{opa_reg[31]}}, opa_reg} : {32'd0, opa_reg};
        b_ext    = sgn_reg ? {{32{opb_reg[31]}}, opb_reg} : {32'd0, opb_reg};
        prod     = a_ext * b_ext;
        mag_b    = (sgn_reg && opb_reg[31]) ? (32'd0 - opb_reg) : opb_reg;
        shifted  = {rem_reg, quo_reg[31]};
        diff     = shifted - {1'b0, mag_b};
        mag_a_in = ((op == OP_DIV) && a[31]) ? (32'd0 - a) : a;
        q_neg    = sgn_reg && (opa_reg[31] ^ opb_reg[31]);
        r_neg    = sgn_reg && opa_reg[31];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            count_reg <= 5'd0;
            fix_reg   <= 1'b0;
            sgn_reg   <= 1'b0;
            opa_reg   <= 32'd0;
            opb_reg   <= 32'd0;
            rem_reg   <= 32'd0;
            quo_reg   <= 32'd0;
        end else begin
            case (state_reg)
                MUL: begin
                    if (done) begin
                        hi_reg    <= prod[63:32];
                        lo_reg    <= prod[31:0];
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= 5'd0;
                    end else begin
                        count_reg <= count_reg + 5'd1;
                    end
                end
                DIV: begin
                    if (!fix_reg) begin
                        if (!diff[32]) begin
                            rem_reg <= diff[31:0];
                            quo_reg <= {quo_reg[30:0], 1'b1};
                        end else begin
                            rem_reg <= shifted[31:0];
                            quo_reg <= {quo_reg[30:0], 1'b0};
                        end
                        if (count_reg == DIV_LAST)
                            fix_reg <= 1'b1;
                        else
                            count_reg <= count_reg + 5'd1;
                    end else begin
                        // Divide by zero returns all-ones quotient and the dividend.
                        if (opb_reg == 32'd0) begin
                            lo_reg <= 32'hFFFF_FFFF;
                            hi_reg <= opa_reg;
                        end else begin
                            lo_reg <= q_neg ? (32'd0 - quo_reg) : quo_reg;
                            hi_reg <= r_neg ? (32'd0 - rem_reg) : rem_reg;
                        end
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= 5'd0;
                        fix_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        sgn_reg   <= (op == OP_MULT);
                        opa_reg   <= a;
                        opb_reg   <= b;
                        state_reg <= MUL;
                        busy_reg  <= 1'b1;
                        count_reg <= 5'd0;
                    end
                    OP_DIV, OP_DIVU: begin
                        sgn_reg   <= (op == OP_DIV);
                        opa_reg   <= a;
                        opb_reg   <= b;
                        quo_reg   <= mag_a_in;
                        rem_reg   <= 32'd0;
                        state_reg <= DIV;
                        busy_reg  <= 1'b1;
                        count_reg <= 5'd0;
                        fix_reg   <= 1'b0;
                    end
                    OP_MTHI: hi_reg <= a;
                    OP_MTLO: lo_reg <= a;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: hand-computed MULT/DIV results, busy timing,
// MTHI/MTLO handling, reset mid-operation and back-to-back issue.
module tb_md_unit;
    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared   = 0;
    int mismatched = 0;

    md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(33)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a one-cycle request; returns at #1 after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        $display("issue op=%0d a=%h b=%h", o, va, vb);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count busy cycles from the current sample point, bounded.
    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_hilo("rst", 32'd0, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(3'd4, 32'h0000_1234, 32'd0);
        check_hilo("mthi", 32'h0000_1234, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);

        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        wait_done("mult_cyc", 5);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu_cyc", 5);
        check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_cyc", 33);
        check_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(3'd3, 32'd100, 32'd7);
        wait_done("divu_cyc", 33);
        check_hilo("divu_100_7", 32'd2, 32'd14);

        issue(3'd3, 32'd10, 32'd0);
        wait_done("divu0_cyc", 33);
        check_hilo("divu_by0", 32'h0000_000A, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf_cyc", 33);
        check_hilo("div_ovf", 32'd0, 32'h8000_0000);

        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_7_m2_cyc", 33);
        check_hilo("div_7_m2", 32'd1, 32'hFFFF_FFFD);

        issue(3'd6, 32'h5555_5555, 32'd0);
        check_hilo("nop", 32'd1, 32'hFFFF_FFFD);
        check("nop_busy", {31'd0, busy}, 32'd0);

        // MTLO during a busy MULT must be dropped; HI/LO hold until completion.
        issue(3'd0, 32'd3, 32'd5);
        issue(3'd5, 32'h0000_DEAD, 32'd0);
        check_hilo("mul_hold", 32'd1, 32'hFFFF_FFFD);
        wait_done("mtlo_busy_cyc", 4);
        check_hilo("mtlo_ignored", 32'd0, 32'd15);

        // Reset in the middle of a DIV, with a competing start in the same cycle.
        issue(3'd3, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        check("div_mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'h0000_0055;
        $display("reset during DIV with MTHI start");
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_hilo("rst_mid", 32'd0, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        check_hilo("rst_no_partial", 32'd0, 32'd0);

        issue(3'd0, 32'd3, 32'd4);
        wait_done("mult34_cyc", 5);
        check_hilo("mult34", 32'd0, 32'd12);

        // Back-to-back: DIVU presented in the last busy cycle of a MULTU.
        issue(3'd1, 32'd6, 32'd7);
        repeat (4) begin @(posedge clk); #1; end
        check("b2b_last_busy", {31'd0, busy}, 32'd1);
        issue(3'd3, 32'd100, 32'd7);
        check("b2b_nogap", {31'd0, busy}, 32'd1);
        check_hilo("b2b_mul", 32'd0, 32'd42);
        wait_done("b2b_div_cyc", 33);
        check_hilo("b2b_div", 32'd2, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy-cycle count for MULT/MULTU (legal range 1..32).
REQ-002 SHALL have parameter DIV_CYCLES, default 33, busy-cycle count for DIV/DIVU: 32 iterations plus 1 sign-fix cycle; fixed value.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request strobe from the EX stage, valid for one cycle.
REQ-006 SHALL have port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port a  input  32  rs operand (dividend, multiplicand, or MTHI/MTLO source).
REQ-008 SHALL have port b  input  32  rt operand (divisor or multiplier).
REQ-009 SHALL have port busy  output  1  high while a multiply or divide is in flight; upstream stalls MFHI/MFLO/MT*/MULT/DIV on it.
REQ-010 SHALL have port hi  output  32  HI register, driven directly from a flop.
REQ-011 SHALL have port lo  output  32  LO register, driven directly from a flop.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV; transitions occur only on rising clk edges.
REQ-013 SHALL accept start only in IDLE with busy=0; start while busy=1 is ignored, with no state, operand, or HI/LO change.
REQ-014 SHALL, on an accepted MTHI (MTLO), load a into hi (lo) at that edge, with no change to busy or the other register.
REQ-015 SHALL, on an accepted op 6-7, do nothing.
REQ-016 SHALL, on an accepted MULT/MULTU at edge T: latch operands and enter MUL; busy=1 for cycles T+1..T+MUL_CYCLES; hi/lo updated and busy=0 at edge T+MUL_CYCLES; return to IDLE.
REQ-017 SHALL produce a 64-bit product, {hi,lo}: MULT two's-complement signed, MULTU unsigned; no overflow flag.
REQ-018 SHALL, on an accepted DIV/DIVU at edge T: enter DIV; busy=1 for DIV_CYCLES cycles; results written at edge T+DIV_CYCLES; return to IDLE.
REQ-019 SHALL compute the divide with a 1-bit-per-cycle restoring or non-restoring divider on magnitudes, with a 5-bit iteration counter that stops after 32 iterations (0..31) and does not wrap.
REQ-020 SHALL write lo=quotient truncated toward zero and hi=remainder carrying the dividend's sign (DIV); DIVU is unsigned.
REQ-021 SHALL, when b=0, write lo=0xFFFFFFFF and hi=a for both DIV and DIVU after the full DIV_CYCLES; no trap.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, write lo=0x80000000 and hi=0x00000000.
REQ-023 SHALL keep hi/lo stable during MUL/DIV, changing them only on the completion edge.
REQ-024 SHALL allow start to be accepted on the cycle busy falls (back-to-back operation).

Reset
REQ-025 SHALL, with reset high at an edge, force state=IDLE, busy=0, hi=0, lo=0, and counter=0, regardless of the operation in flight.
REQ-026 SHALL give reset priority over start in the same cycle; the start is dropped.
REQ-027 SHALL discard any partial result when reset occurs mid-operation; hi/lo never take a partial value.

Verification
REQ-028 SHALL pass: MULT a=0xFFFFFFFF b=2 -> busy for 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU with the same operands -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-029 SHALL pass: DIV a=0xFFFFFFF9 (-7) b=2 -> busy for exactly 33 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 100/7 -> lo=14 hi=2.
REQ-030 SHALL pass: DIVU a=10 b=0 -> lo=0xFFFFFFFF hi=0x0000000A; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-031 SHALL pass: MTHI a=0x1234 in IDLE -> hi=0x1234 next cycle, lo unchanged; MTLO issued during a busy MULT -> ignored, final lo=product.
REQ-032 SHALL pass: reset asserted at cycle 10 of a DIV -> next cycle busy=0 hi=0 lo=0; a new MULT 3*4 then yields lo=12 hi=0.
REQ-033 SHALL pass: second start issued on the cycle busy falls -> accepted; busy stays high with no gap; both results correct in sequence.
